// File: rtl/rm84_soft_encoder.sv
// (8,4) extended-Hamming encoder with BPSK soft-symbol mapping.
// Accepts one 4-bit message per frame and streams 8 signed symbols out, index 0 first.
`timescale 1ns/1ps
module rm84_soft_encoder #(
  parameter int          AMP   = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       in_msg,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_sym,
  output logic [2:0]       out_idx,
  output logic             out_sof,
  output logic             out_eof,
  output logic [CNT_W-1:0] frame_cnt
);

  if (AMP < 1 || AMP > 31) begin : g_amp_check
    $error("rm84_soft_encoder: AMP must be within 1..31");
  end

  localparam logic [5:0] SymPos = AMP[5:0];
  localparam logic [5:0] SymNeg = 6'd0 - SymPos;

  typedef enum logic {StIdle, StSend} state_e;

  state_e     state_q;
  logic [3:0] msg_q;
  logic [2:0] idx_q;
  logic [7:0] code;
  logic       last;

  assign code = {msg_q[1] ^ msg_q[2] ^ msg_q[3],
                 msg_q[0] ^ msg_q[2] ^ msg_q[3],
                 msg_q[0] ^ msg_q[1] ^ msg_q[3],
                 msg_q[0] ^ msg_q[1] ^ msg_q[2],
                 msg_q};

  assign last = (idx_q == 3'd7);

  // Ready in the final symbol's handshake cycle lets frames run back-to-back.
  assign in_ready = (state_q == StIdle) | ((state_q == StSend) & last & out_ready);

  assign out_sym = code[idx_q] ? SymPos : SymNeg;
  assign out_idx = idx_q;
  assign out_sof = (idx_q == 3'd0);
  assign out_eof = last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      out_valid <= 1'b0;
      msg_q     <= 4'd0;
      idx_q     <= 3'd0;
      frame_cnt <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            msg_q     <= in_msg;
            idx_q     <= 3'd0;
            state_q   <= StSend;
            out_valid <= 1'b1;
          end
        end
        StSend: begin
          if (out_ready) begin
            if (!last) begin
              idx_q <= idx_q + 3'd1;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
              idx_q     <= 3'd0;
              if (in_valid) begin
                msg_q <= in_msg;
              end else begin
                state_q   <= StIdle;
                out_valid <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rm84_soft_encoder.sv
// Directed bench for rm84_soft_encoder: code table, handshake, backpressure, reset,
// back-to-back frames and a correlation-decoder loopback at AMP = 8, 31 and 1.
`timescale 1ns/1ps
module tb_rm84_soft_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_msg;
  logic        out_ready;

  logic        in_ready8, out_valid8, sof8, eof8;
  logic [5:0]  sym8;
  logic [2:0]  idx8;
  logic [15:0] cnt8;
  logic        in_ready31, out_valid31, sof31, eof31;
  logic [5:0]  sym31;
  logic [2:0]  idx31;
  logic [15:0] cnt31;
  logic        in_ready1, out_valid1, sof1, eof1;
  logic [5:0]  sym1;
  logic [2:0]  idx1;
  logic [15:0] cnt1;

  int errors = 0;
  int checks = 0;
  int exp_frames = 0;
  logic [47:0] cap8, cap31, cap1;

  always #5 clk = ~clk;

  rm84_soft_encoder #(.AMP(8), .CNT_W(16)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_msg(in_msg), .in_ready(in_ready8),
    .out_valid(out_valid8), .out_ready(out_ready), .out_sym(sym8), .out_idx(idx8),
    .out_sof(sof8), .out_eof(eof8), .frame_cnt(cnt8)
  );

  rm84_soft_encoder #(.AMP(31), .CNT_W(16)) u_dut31 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_msg(in_msg), .in_ready(in_ready31),
    .out_valid(out_valid31), .out_ready(out_ready), .out_sym(sym31), .out_idx(idx31),
    .out_sof(sof31), .out_eof(eof31), .frame_cnt(cnt31)
  );

  rm84_soft_encoder #(.AMP(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_msg(in_msg), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_sym(sym1), .out_idx(idx1),
    .out_sof(sof1), .out_eof(eof1), .frame_cnt(cnt1)
  );

  // Codewords worked out by hand, bit i = code bit d[i].
  function automatic logic [7:0] code_of(input logic [3:0] m);
    case (m)
      4'h0: code_of = 8'h00;  4'h1: code_of = 8'h71;
      4'h2: code_of = 8'hB2;  4'h3: code_of = 8'hC3;
      4'h4: code_of = 8'hD4;  4'h5: code_of = 8'hA5;
      4'h6: code_of = 8'h66;  4'h7: code_of = 8'h17;
      4'h8: code_of = 8'hE8;  4'h9: code_of = 8'h99;
      4'hA: code_of = 8'h5A;  4'hB: code_of = 8'h2B;
      4'hC: code_of = 8'h3C;  4'hD: code_of = 8'h4D;
      4'hE: code_of = 8'h8E;  default: code_of = 8'hFF;
    endcase
  endfunction

  function automatic logic [5:0] exp_sym(input logic b, input int amp);
    logic [5:0] a;
    a = amp[5:0];
    exp_sym = b ? a : (6'd0 - a);
  endfunction

  // Maximum-correlation soft decoder over the 16 codewords.
  function automatic int decode(input logic [47:0] s);
    int best, best_m, corr, v;
    logic [7:0] cw;
    best = -100000;
    best_m = 0;
    for (int m = 0; m < 16; m++) begin
      cw = code_of(m[3:0]);
      corr = 0;
      for (int i = 0; i < 8; i++) begin
        v = int'($signed(s[i*6 +: 6]));
        corr = cw[i] ? corr + v : corr - v;
      end
      if (corr > best) begin
        best = corr;
        best_m = m;
      end
    end
    decode = best_m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [3:0] msg);
    check("start_in_ready", 32'(in_ready8), 32'd1);
    in_valid = 1'b1;
    in_msg   = msg;
    step();
    in_valid = 1'b0;
    in_msg   = 4'h0;
  endtask

  // Walks one frame already accepted by the DUT; optionally stalls at stall_idx.
  task automatic frame(input logic [3:0] msg, input int stall_idx, input int stall_len);
    logic [7:0] cw;
    cw = code_of(msg);
    for (int k = 0; k < 8; k++) begin
      if (k == stall_idx) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          step();
          check("stall_idx", 32'(idx8), k);
          check("stall_sym", 32'(sym8), 32'(exp_sym(cw[k], 8)));
          check("stall_valid", 32'(out_valid8), 32'd1);
          check("stall_in_ready", 32'(in_ready8), 32'd0);
        end
        out_ready = 1'b1;
      end
      check("valid", 32'(out_valid8), 32'd1);
      check("idx", 32'(idx8), k);
      check("sof", 32'(sof8), 32'(k == 0));
      check("eof", 32'(eof8), 32'(k == 7));
      check("in_ready", 32'(in_ready8), 32'(k == 7));
      check("sym_a8", 32'(sym8), 32'(exp_sym(cw[k], 8)));
      check("sym_a31", 32'(sym31), 32'(exp_sym(cw[k], 31)));
      check("sym_a1", 32'(sym1), 32'(exp_sym(cw[k], 1)));
      cap8[k*6 +: 6]  = sym8;
      cap31[k*6 +: 6] = sym31;
      cap1[k*6 +: 6]  = sym1;
      step();
    end
    exp_frames++;
    check("frame_cnt", 32'(cnt8), exp_frames);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_msg    = 4'h0;
    out_ready = 1'b1;
    step();
    step();
    check("rst_valid", 32'(out_valid8), 32'd0);
    check("rst_in_ready", 32'(in_ready8), 32'd1);
    check("rst_cnt", 32'(cnt8), 32'd0);
    check("rst_sym", 32'(sym8), 32'h38);
    reset = 1'b0;

    start(4'hF);
    frame(4'hF, -1, 0);
    check("idle_valid", 32'(out_valid8), 32'd0);
    start(4'h0);
    frame(4'h0, -1, 0);
    start(4'h1);
    frame(4'h1, -1, 0);

    // Backpressure on index 3 for five cycles.
    start(4'hA);
    frame(4'hA, 3, 5);

    // Asynchronous reset in the middle of a frame.
    start(4'h5);
    repeat (5) step();
    check("mid_idx", 32'(idx8), 32'd5);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid8), 32'd0);
    check("mid_rst_cnt", 32'(cnt8), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready8), 32'd1);
    check("mid_rst_sym", 32'(sym8), 32'h38);
    exp_frames = 0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Back-to-back frames with in_valid held.
    in_valid = 1'b1;
    in_msg   = 4'h3;
    step();
    in_msg = 4'hC;
    frame(4'h3, -1, 0);
    in_valid = 1'b0;
    frame(4'hC, -1, 0);
    check("b2b_cnt", 32'(cnt8), 32'd2);
    check("b2b_idle", 32'(out_valid8), 32'd0);

    // Loopback through a soft decoder at three amplitudes.
    for (int m = 0; m < 16; m++) begin
      start(m[3:0]);
      frame(m[3:0], -1, 0);
      check("loop_dec_a8", decode(cap8), m);
      check("loop_dec_a31", decode(cap31), m);
      check("loop_dec_a1", decode(cap1), m);
    end
    check("loop_cnt_a31", 32'(cnt31), 32'd18);
    check("loop_cnt_a1", 32'(cnt1), 32'd18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
